// File: rtl/comptador_modular_if.sv
// rtl/comptador_modular_if.sv - control and status bundle for the modulo counter
interface comptador_modular_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    modport master (
        output clear, load, load_val, en, up,
        input  count, tc, ovf
    );

    modport slave (
        input  clear, load, load_val, en, up,
        output count, tc, ovf
    );
endinterface

// File: rtl/comptador_modular.sv
// rtl/comptador_modular.sv - parametrised modulo up/down counter with wrap/saturate, tc pulse and sticky ovf
module comptador_modular #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    comptador_modular_if.slave  bus
);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             ovf_q;

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;

    // Bounds are full-width compares so MAX_VAL can be any value, not just 2**n-1.
    assign at_max       = (count_q == MAX_VAL);
    assign at_zero      = (count_q == ZERO);
    assign load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= ZERO;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.clear) begin
            count_q <= ZERO;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.load) begin
            count_q <= load_clamped;
            tc_q    <= 1'b0;
        end else if (bus.en) begin
            if (bus.up) begin
                if (!at_max) begin
                    count_q <= count_q + ONE;
                    tc_q    <= 1'b0;
                end else begin
                    count_q <= SATURATE ? MAX_VAL : ZERO;
                    tc_q    <= 1'b1;
                    ovf_q   <= 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_q <= count_q - ONE;
                    tc_q    <= 1'b0;
                end else begin
                    count_q <= SATURATE ? ZERO : MAX_VAL;
                    tc_q    <= 1'b1;
                    ovf_q   <= 1'b1;
                end
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
endmodule
